// File: rtl/rx_datapath_fifo_pkg.sv
// Shared constants for the UART receive datapath: shift-register width, FIFO entry layout
// and the frame-length helper. RX_BREAK_DET_EN widens each entry by one break bit.
package uart_rx_pkg;

    localparam int SR_W     = 10;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 8;
    localparam int PERR_BIT = 8;
    localparam int FERR_BIT = 9;
`ifdef RX_BREAK_DET_EN
    localparam int BRK_BIT  = 10;
    localparam int ENTRY_W  = 11;
`else
    localparam int ENTRY_W  = 10;
`endif

    // Data bits + optional parity bit + one stop bit.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/rx_datapath_fifo_if.sv
// Control-FSM strobes, mode bits and host read port of the receive datapath.
// master drives the strobes/read and observes the head; slave is the datapath.
interface rx_datapath_fifo_if;
    logic       i_btu;
    logic       i_start;
    logic       i_done;
    logic       i_rx;
    logic       i_eight;
    logic       i_pen;
    logic       i_ohel;
    logic       i_read;
    logic       o_rxrdy;
    logic [7:0] o_rx_byte;
    logic       o_perr;
    logic       o_ferr;
    logic       o_ovf;
`ifdef RX_BREAK_DET_EN
    logic       o_brk;
`endif

    modport master (
        output i_btu, i_start, i_done, i_rx, i_eight, i_pen, i_ohel, i_read,
`ifdef RX_BREAK_DET_EN
        input  o_brk,
`endif
        input  o_rxrdy, o_rx_byte, o_perr, o_ferr, o_ovf
    );

    modport slave (
        input  i_btu, i_start, i_done, i_rx, i_eight, i_pen, i_ohel, i_read,
`ifdef RX_BREAK_DET_EN
        output o_brk,
`endif
        output o_rxrdy, o_rx_byte, o_perr, o_ferr, o_ovf
    );

endinterface

// File: rtl/rx_sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through from registered storage, 1-cycle push-to-head.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module rx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rx_datapath_fifo.sv
// UART RX datapath: deserialise, check parity/framing, queue frames; head valid 1 cycle after i_done.
// Frames arriving while full (without a same-cycle pop) are dropped and set sticky o_ovf; RX_BREAK_DET_EN adds o_brk.
module rx_datapath_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    rx_datapath_fifo_if.slave  rx
);

    logic [SR_W-1:0]    sr_q, sr_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         rshift;
    logic [SR_W-1:0]    remap;
    logic [7:0]         data;
    logic               par_bit;
    logic               stop_bit;
    logic               perr;
    logic               ferr;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               pop_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW:0]        fifo_count;

    always_comb begin
        sr_d = sr_q;
        if (rx.i_start) begin
            sr_d = '0;
        end else if (rx.i_btu) begin
            sr_d = {rx.i_rx, sr_q[SR_W-1:1]};
        end
    end

    // Shorter frames sit high in the register; shift so the first data bit is at bit 0.
    always_comb begin
        rshift   = 4'(SR_W) - frame_len(rx.i_eight, rx.i_pen);
        remap    = sr_q >> rshift;
        data     = {rx.i_eight & remap[7], remap[6:0]};
        par_bit  = rx.i_eight ? remap[8] : remap[7];
        case ({rx.i_eight, rx.i_pen})
            2'b00:   stop_bit = remap[7];
            2'b11:   stop_bit = remap[9];
            default: stop_bit = remap[8];
        endcase
        perr = rx.i_pen & ((^data ^ rx.i_ohel) != par_bit);
        ferr = ~stop_bit;

        push_entry                          = '0;
        push_entry[DATA_LSB +: DATA_W]      = data;
        push_entry[PERR_BIT]                = perr;
        push_entry[FERR_BIT]                = ferr;
`ifdef RX_BREAK_DET_EN
        push_entry[BRK_BIT] = (data == 8'h00) & ~stop_bit & (~par_bit | ~rx.i_pen);
`endif
    end

    // A same-cycle overflow outranks the clearing pop.
    always_comb begin
        pop_ok = rx.i_read & ~fifo_empty;
        ovf_d  = ovf_q;
        if (pop_ok) begin
            ovf_d = 1'b0;
        end
        if (rx.i_done & fifo_full & ~pop_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sr_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            ovf_q <= ovf_d;
        end
    end

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .AW    (AW)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (rx.i_done),
        .push_dat (push_entry),
        .pop      (pop_ok),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign rx.o_rxrdy   = (fifo_count != '0);
    assign rx.o_rx_byte = fifo_empty ? 8'h00 : head[DATA_LSB +: DATA_W];
    assign rx.o_perr    = ~fifo_empty & head[PERR_BIT];
    assign rx.o_ferr    = ~fifo_empty & head[FERR_BIT];
    assign rx.o_ovf     = ovf_q;
`ifdef RX_BREAK_DET_EN
    assign rx.o_brk     = ~fifo_empty & head[BRK_BIT];
`endif

endmodule

// File: tb/tb_rx_datapath_fifo.sv
// Directed bench for rx_datapath_fifo (DEPTH=4): frame formats, error flags, overflow, full push+pop, reset.
module tb_rx_datapath_fifo;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    rx_datapath_fifo_if rx_if ();

    rx_datapath_fifo #(.DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .rx      (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] bits, input int n);
        rx_if.i_start = 1'b1;
        tick();
        rx_if.i_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_if.i_rx  = bits[i];
            rx_if.i_btu = 1'b1;
            tick();
            rx_if.i_btu = 1'b0;
        end
    endtask

    task automatic rx_frame(input logic [9:0] bits, input int n, input logic rd);
        send_bits(bits, n);
        rx_if.i_done = 1'b1;
        rx_if.i_read = rd;
        tick();
        rx_if.i_done = 1'b0;
        rx_if.i_read = 1'b0;
    endtask

    task automatic pop_one();
        rx_if.i_read = 1'b1;
        tick();
        rx_if.i_read = 1'b0;
    endtask

    task automatic set_mode(input logic eight, input logic pen, input logic ohel);
        rx_if.i_eight = eight;
        rx_if.i_pen   = pen;
        rx_if.i_ohel  = ohel;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rxrdy"}, 32'(rx_if.o_rxrdy), 32'd0);
        check({tag, "_byte"},  32'(rx_if.o_rx_byte), 32'h00);
        check({tag, "_perr"},  32'(rx_if.o_perr), 32'd0);
        check({tag, "_ferr"},  32'(rx_if.o_ferr), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        rx_if.i_btu = 1'b0; rx_if.i_start = 1'b0; rx_if.i_done = 1'b0;
        rx_if.i_rx  = 1'b1; rx_if.i_read  = 1'b0;
        set_mode(1'b1, 1'b1, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_idle("reset");
        check("reset_ovf", 32'(rx_if.o_ovf), 32'd0);

        // 8E1: data 0x6C, parity 0, stop 1
        rx_frame(10'h26C, 10, 1'b0);
        check("e8_rxrdy", 32'(rx_if.o_rxrdy), 32'd1);
        check("e8_byte",  32'(rx_if.o_rx_byte), 32'h6C);
        check("e8_perr",  32'(rx_if.o_perr), 32'd0);
        check("e8_ferr",  32'(rx_if.o_ferr), 32'd0);
        set_mode(1'b0, 1'b0, 1'b1);
        tick();
        check("e8_mode_chg_byte", 32'(rx_if.o_rx_byte), 32'h6C);
        set_mode(1'b1, 1'b1, 1'b0);
        pop_one();
        check_idle("e8_pop");

        rx_frame(10'h36C, 10, 1'b0);
        check("e8_badpar_perr", 32'(rx_if.o_perr), 32'd1);
        check("e8_badpar_byte", 32'(rx_if.o_rx_byte), 32'h6C);
        pop_one();

        rx_frame(10'h06C, 10, 1'b0);
        check("e8_badstop_ferr", 32'(rx_if.o_ferr), 32'd1);
        check("e8_badstop_perr", 32'(rx_if.o_perr), 32'd0);
        pop_one();
        check_idle("e8_badstop_pop");

        // 7N1: 1,0,1,0,1,0,1 then stop 1
        set_mode(1'b0, 1'b0, 1'b0);
        rx_frame(10'h0D5, 8, 1'b0);
        check("n7_byte", 32'(rx_if.o_rx_byte), 32'h55);
        check("n7_perr", 32'(rx_if.o_perr), 32'd0);
        check("n7_ferr", 32'(rx_if.o_ferr), 32'd0);
        pop_one();

        // 7O1: four ones, odd parity bit must be 1
        set_mode(1'b0, 1'b1, 1'b1);
        rx_frame(10'h1D5, 9, 1'b0);
        check("o7_byte", 32'(rx_if.o_rx_byte), 32'h55);
        check("o7_perr", 32'(rx_if.o_perr), 32'd0);
        check("o7_ferr", 32'(rx_if.o_ferr), 32'd0);
        pop_one();
        rx_frame(10'h155, 9, 1'b0);
        check("o7_badpar_perr", 32'(rx_if.o_perr), 32'd1);
        pop_one();
        check("o7_pop_rxrdy", 32'(rx_if.o_rxrdy), 32'd0);

        // 8N1 overflow: five frames into four entries
        set_mode(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            rx_frame({2'b01, 8'(k)}, 9, 1'b0);
        end
        check("ovf_set", 32'(rx_if.o_ovf), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_head%0d", k), 32'(rx_if.o_rx_byte), 32'(k));
            pop_one();
            if (k == 1) check("ovf_clear", 32'(rx_if.o_ovf), 32'd0);
        end
        check("ovf_drained_rxrdy", 32'(rx_if.o_rxrdy), 32'd0);

        // Full FIFO with push and pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            rx_frame({2'b01, 8'(8'h11 + k)}, 9, 1'b0);
        end
        rx_frame({2'b01, 8'h15}, 9, 1'b1);
        check("fullpp_ovf", 32'(rx_if.o_ovf), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fullpp_head%0d", k), 32'(rx_if.o_rx_byte), 32'(8'h12 + k));
            pop_one();
        end
        check("fullpp_rxrdy", 32'(rx_if.o_rxrdy), 32'd0);

        // Reset mid-frame with two entries stored
        rx_frame({2'b01, 8'h21}, 9, 1'b0);
        rx_frame({2'b01, 8'h22}, 9, 1'b0);
        send_bits(10'h3FF, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("rstmid");
        check("rstmid_ovf", 32'(rx_if.o_ovf), 32'd0);
        rx_frame({2'b01, 8'hA5}, 9, 1'b0);
        check("post_rst_byte", 32'(rx_if.o_rx_byte), 32'hA5);
        check("post_rst_ferr", 32'(rx_if.o_ferr), 32'd0);
        pop_one();
        check("post_rst_rxrdy", 32'(rx_if.o_rxrdy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_datapath_fifo.md
# rx_datapath_fifo

Parametrised UART receive datapath: deserialises the frame bits sampled by the RX control FSM, right-justifies them for 7/8-bit and parity/no-parity formats, checks parity and framing, and pushes each completed frame with its error flags into a DEPTH-entry receive FIFO. It sits between the RX bit-timing/control FSM (which supplies `i_btu`, `i_start`, `i_done`) and the host read interface. It is the successor to the single-register RX datapath, buffering DEPTH frames instead of one.

## Interface
- `DEPTH`, 4: FIFO entries; a power of two, 2..64.
- `AW`, $clog2(DEPTH): FIFO pointer width; derived, do not override.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset; one clock, synchronous, active-low.
- `i_btu`  in  1  bit-time-up strobe, 1 cycle, at each bit centre.
- `i_start`  in  1  high while the control FSM samples the start bit.
- `i_done`  in  1  frame-complete strobe, 1 cycle.
- `i_rx`  in  1  synchronised serial line.
- `i_eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `i_pen`  in  1  parity enable.
- `i_ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `i_read`  in  1  pop request; ignored when empty.
- `o_rxrdy`  out  1  FIFO not empty.
- `o_rx_byte`  out  8  head data; bit 7 = 0 in 7-bit mode; 0 when empty.
- `o_perr`  out  1  head parity error; 0 when empty.
- `o_ferr`  out  1  head framing error; 0 when empty.
- `o_ovf`  out  1  sticky overflow.
- `o_brk`  out  1  head break flag; present only with `RX_BREAK_DET_EN`.

## Operation
- Shift register: 10 bits. On `i_btu & ~i_start`, shift right with `i_rx` entering bit 9. Cleared to 0 on `i_start`.
- Frame length N = 8 + `i_eight` + `i_pen`; this counts the data bits, the parity bit and one stop bit.
- Remap: shift the register right by 10−N so the first data bit lands at bit 0.
- Fields: data = remap[6:0], plus remap[7] when `i_eight`. The parity bit is remap[7+`i_eight`]. The stop bit is remap[7+`i_eight`+`i_pen`].
- perr = `i_pen` & ((^data ^ `i_ohel`) != parity bit).
- ferr = ~stop bit.
- Push: on `i_done`, write {brk, ferr, perr, data} into the FIFO if it is not full.
- Push while full, with no pop in the same cycle: the frame is dropped, `o_ovf` is set, and the FIFO contents are unchanged.
- Pop: on `i_read` while not empty, advance the read pointer.
- `o_ovf` clears on the first successful pop after it was set. If an overflow and a pop occur in the same cycle, the set wins.
- Simultaneous push and pop while full: both happen, no overflow.
- Simultaneous push and pop while empty: the push happens; the pop is ignored.
- Mode inputs are sampled at `i_done`. Changing them mid-frame has no effect on entries already stored.

## Timing
- Reset: pointers 0, count 0, shift register 0, and `o_ovf` 0. Consequently `o_rxrdy`, `o_rx_byte`, `o_perr`, `o_ferr` and `o_brk` are all 0 the cycle after reset.
- Reset mid-frame discards the partial frame and all stored entries.
- Push latency: `i_done` at edge t makes `o_rxrdy` and the head fields valid after edge t (first-word fall-through from registered storage).
- Pop: `i_read` at edge t presents the next entry after edge t. `o_rxrdy` falls after t if that was the last entry.
- Count range is 0..DEPTH. Pointers wrap modulo DEPTH; full and empty are distinguished by the count.

## Configuration
- `RX_BREAK_DET_EN` defined: brk = (data == 0) & ~stop bit & (parity bit == 0 or `i_pen` = 0). It is stored per entry and presented on `o_brk`.
- `RX_BREAK_DET_EN` undefined: the `o_brk` port and its storage bit are absent; the entry width is 10.

## Structure
- Package `uart_rx_pkg`:
  - shift-register width 10;
  - entry field offsets;
  - frame-length helper (N from eight/pen).
- Sub-module `rx_sync_fifo`: a generic synchronous FIFO parametrised by `DEPTH` and entry width. It provides push/pop ports, full/empty/count outputs and a registered memory.
- The shift register, remap and error checks remain in the top-level block.

## Test plan
- 8-bit, even parity (`i_eight`=1, `i_pen`=1, `i_ohel`=0): shift 0,0,1,1,0,1,1,0, parity 0, stop 1, then `i_done` → `o_rx_byte`=0x6C, `o_perr`=0, `o_ferr`=0, `o_rxrdy`=1.
- Same frame with parity bit 1 → `o_perr`=1. With stop bit 0 → `o_ferr`=1. After `i_read`, `o_rxrdy`=0 and all head fields are 0.
- 7-bit, no parity: shift 1,0,1,0,1,0,1, stop 1 → `o_rx_byte`=0x55. Repeat with `i_ohel`=1 and `i_pen`=1, parity bit 1 → `o_perr`=0.
- DEPTH=4, push frames 0x01..0x05 with no reads → `o_ovf`=1, then 4 reads return 0x01..0x04. `o_ovf` clears after the first read.
- Full FIFO with `i_done` and `i_read` in the same cycle → no `o_ovf`, count stays 4, and the new frame is returned last.
- `i_rst_n`=0 mid-frame with 2 entries stored → all outputs 0 after the edge. A subsequent clean frame is received correctly.
